// File: rtl/memlcd_pkg.sv
// Shared definitions for the memory-LCD frame sequencer: command byte
// values, state encoding and the frame size helper.
package memlcd_pkg;

    localparam logic [7:0] CMD_FRAME   = 8'h80;
    localparam logic [7:0] CMD_FILL    = 8'h40;
    localparam logic [7:0] CMD_CLEAR   = 8'h20;
    localparam logic [7:0] CMD_PATTERN = 8'h60;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 3'd0;
    localparam seq_state_t ST_STREAM   = 3'd1;
    localparam seq_state_t ST_FILL_ARG = 3'd2;
    localparam seq_state_t ST_FILL     = 3'd3;
    localparam seq_state_t ST_DISCARD  = 3'd4;
    localparam seq_state_t ST_PATTERN  = 3'd5;

    function automatic int frame_bytes(input int h_bytes, input int v_lines);
        return h_bytes * v_lines;
    endfunction

endpackage

// File: rtl/memlcd_frame_sequencer_if.sv
// Bundle of the byte-receiver, FIFO-write and status signals of the
// frame sequencer. The slave side is the sequencer itself.
interface memlcd_frame_sequencer_if;

    logic [7:0] i_rx_data;
    logic       i_rx_dataValid;
    logic       i_spi_nss;
    logic       i_wfull;
    logic       i_wfull_almost;
    logic       i_clr_err;
    logic [7:0] o_wdata;
    logic       o_winc;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_overflow;
    logic       o_short_frame;

    modport master (
        output i_rx_data, i_rx_dataValid, i_spi_nss, i_wfull, i_wfull_almost, i_clr_err,
        input  o_wdata, o_winc, o_busy, o_frame_done, o_overflow, o_short_frame
    );

    modport slave (
        input  i_rx_data, i_rx_dataValid, i_spi_nss, i_wfull, i_wfull_almost, i_clr_err,
        output o_wdata, o_winc, o_busy, o_frame_done, o_overflow, o_short_frame
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (SPI chip select).
// Resets to 1 so an idle (deselected) bus is seen during and after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // Shift the raw level through two flops before anyone looks at it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/memlcd_frame_sequencer.sv
// Command-level sequencer between the SPI byte receiver and the afifo
// write port. The first byte of a packet selects streaming, solid fill,
// clear or discard; writes are throttled against FIFO full and each frame
// is counted so the LCD reader only ever sees whole frames.
// Optional build macro: MEMLCD_TEST_PATTERN_EN adds the 0x60 test-pattern
// command (write k carries k[7:0]); without it 0x60 is discarded.
module memlcd_frame_sequencer
    import memlcd_pkg::*;
#(
    parameter int H_BYTES = 64,
    parameter int V_LINES = 240
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    memlcd_frame_sequencer_if.slave bus
);

    localparam int FRAME_BYTES = frame_bytes(H_BYTES, V_LINES);
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BYTES);

    seq_state_t       state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_last;
    logic [7:0]       fill_value;
    logic             nss_s;
    logic             nss_prev;
    logic             nss_rise;
    logic             slot_free;

    sync_2ff #(.RESET_VAL(1'b1)) u_nss_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (bus.i_spi_nss),
        .o_q     (nss_s)
    );

    // A write in flight plus "one entry left" means the next slot is taken
    assign slot_free = !bus.i_wfull && !(bus.o_winc && bus.i_wfull_almost);
    assign nss_rise  = nss_s && !nss_prev;
    assign cnt_inc   = (counter == FRAME_CNT) ? counter : counter + 1'b1;
    assign cnt_last  = (cnt_inc == FRAME_CNT);
    assign bus.o_busy = (state != ST_IDLE);

    // Command decode, per-state write generation, frame counting and sticky flags
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= ST_IDLE;
            counter           <= '0;
            fill_value        <= 8'h00;
            nss_prev          <= 1'b1;
            bus.o_wdata       <= 8'h00;
            bus.o_winc        <= 1'b0;
            bus.o_frame_done  <= 1'b0;
            bus.o_overflow    <= 1'b0;
            bus.o_short_frame <= 1'b0;
        end else begin
            nss_prev         <= nss_s;
            bus.o_winc       <= 1'b0;
            bus.o_frame_done <= 1'b0;
            if (bus.i_clr_err) begin
                bus.o_overflow    <= 1'b0;
                bus.o_short_frame <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.i_rx_dataValid) begin
                        counter <= '0;
                        case (bus.i_rx_data)
                            CMD_FRAME: state <= ST_STREAM;
                            CMD_FILL:  state <= ST_FILL_ARG;
                            CMD_CLEAR: begin
                                fill_value <= 8'h00;
                                state      <= ST_FILL;
                            end
`ifdef MEMLCD_TEST_PATTERN_EN
                            CMD_PATTERN: state <= ST_PATTERN;
`endif
                            default:   state <= ST_DISCARD;
                        endcase
                    end
                end
                ST_STREAM: begin
                    if (bus.i_rx_dataValid) begin
                        counter <= cnt_inc;
                        if (slot_free) begin
                            bus.o_winc  <= 1'b1;
                            bus.o_wdata <= bus.i_rx_data;
                        end else begin
                            bus.o_overflow <= 1'b1;
                        end
                    end
                    if (bus.i_rx_dataValid && cnt_last) begin
                        bus.o_frame_done <= 1'b1;
                        state            <= ST_DISCARD;
                    end else if (nss_rise) begin
                        bus.o_short_frame <= 1'b1;
                        state             <= ST_IDLE;
                    end
                end
                ST_FILL_ARG: begin
                    if (bus.i_rx_dataValid) begin
                        fill_value <= bus.i_rx_data;
                        counter    <= '0;
                        state      <= ST_FILL;
                    end else if (nss_rise) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (slot_free) begin
                        bus.o_winc  <= 1'b1;
                        bus.o_wdata <= fill_value;
                        counter     <= cnt_inc;
                        if (cnt_last) begin
                            bus.o_frame_done <= 1'b1;
                            state            <= ST_IDLE;
                        end
                    end
                end
`ifdef MEMLCD_TEST_PATTERN_EN
                ST_PATTERN: begin
                    if (slot_free) begin
                        bus.o_winc  <= 1'b1;
                        bus.o_wdata <= 8'(counter);
                        counter     <= cnt_inc;
                        if (cnt_last) begin
                            bus.o_frame_done <= 1'b1;
                            state            <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_DISCARD: begin
                    if (nss_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
